// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment display controller.
// Mode encodings, blank entry value and hex segment table.
package seg_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_SCROLL = 2'b01,
        MODE_BLINK  = 2'b10
    } mode_e;

    localparam int unsigned NDIG = 8;

    localparam logic [4:0] BLANK = 5'h10;

    // Index 0 sits in the low byte; bit7=a .. bit1=g, bit0=dp.
    localparam logic [15:0][7:0] HEX_TAB = {
        8'h8E, 8'h9E, 8'h7A, 8'h9C,
        8'h3E, 8'hEE, 8'hF6, 8'hFE,
        8'hE0, 8'hBE, 8'hB6, 8'h66,
        8'hF2, 8'hDA, 8'h60, 8'hFC
    };

    function automatic logic [7:0] hex_pat(
        input logic [3:0] d
    );
        return HEX_TAB[d];
    endfunction

endpackage

// File: rtl/seg_hex_dec.sv
// Buffer entry to active-high segment pattern.
// Bit 4 of the entry blanks the digit entirely.
module seg_hex_dec
    import seg_pkg::*;
(
    input  logic [4:0] entry_i,
    output logic [7:0] pat_o
);

    // Blank wins over the hex value; dp is added by the caller.
    always_comb begin
        pat_o = 8'h00;
        if (!entry_i[4]) begin
            pat_o = hex_pat(entry_i[3:0]);
        end
    end

endmodule

// File: rtl/seg_disp_ctrl.sv
// Eight-digit 7-segment controller: shared digit buffer,
// round-robin write arbiter, prescaled scroll/blink.
module seg_disp_ctrl
    import seg_pkg::*;
#(
    parameter logic [31:0] CLK_NUM = 32'd5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [2:0] req0_idx,
    input  logic [4:0] req0_data,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [2:0] req1_idx,
    input  logic [4:0] req1_data,
    input  logic [1:0] mode,
    input  logic [7:0] dp,
    output logic [7:0] o_seg0,
    output logic [7:0] o_seg1,
    output logic [7:0] o_seg2,
    output logic [7:0] o_seg3,
    output logic [7:0] o_seg4,
    output logic [7:0] o_seg5,
    output logic [7:0] o_seg6,
    output logic [7:0] o_seg7
);

    logic [7:0][4:0] buf_q, buf_d;
    logic [31:0]     count_q, count_d;
    logic [2:0]      offset_q, offset_d;
    logic            phase_q, phase_d;
    logic            rr_q, rr_d;
    logic [7:0][7:0] seg_q, seg_d;

    logic            grant0, grant1;
    logic            tick;
    logic [7:0][2:0] eidx;
    logic [7:0][7:0] pat;

    // Grant: a lone requester wins; on contention the pointer decides.
    always_comb begin
        req0_ready = req0_valid & (~req1_valid | ~rr_q);
        req1_ready = req1_valid & (~req0_valid | rr_q);
        grant0     = req0_valid & req0_ready;
        grant1     = req1_valid & req1_ready;
    end

    // Buffer write, prescaler, scroll offset, blink phase, rr pointer.
    always_comb begin
        buf_d    = buf_q;
        count_d  = count_q + 32'd1;
        offset_d = offset_q;
        phase_d  = 1'b0;
        rr_d     = rr_q;
        tick     = (count_q == CLK_NUM);
        if (grant0) begin
            buf_d[req0_idx] = req0_data;
            rr_d            = 1'b1;
        end else if (grant1) begin
            buf_d[req1_idx] = req1_data;
            rr_d            = 1'b0;
        end
        if (tick) begin
            count_d = 32'd0;
        end
        if (mode == MODE_SCROLL && tick) begin
            offset_d = offset_q + 3'd1;
        end
        if (mode == MODE_BLINK) begin
            phase_d = tick ? ~phase_q : phase_q;
        end
    end

    // Position N looks at entry (offset+N) mod 8.
    always_comb begin
        for (int n = 0; n < NDIG; n++) begin
            eidx[n] = offset_q + 3'(n);
        end
    end

    for (genvar g = 0; g < NDIG; g++) begin : g_dec
        seg_hex_dec u_dec (
            .entry_i (buf_q[eidx[g]]),
            .pat_o   (pat[g])
        );
    end

    // Add dp, invert for active-low drive, blank during blink-off.
    always_comb begin
        for (int n = 0; n < NDIG; n++) begin
            seg_d[n] = ~(pat[n] | {7'b0, dp[n]});
            if (phase_q) begin
                seg_d[n] = 8'hFF;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q    <= {NDIG{BLANK}};
            count_q  <= 32'd0;
            offset_q <= 3'd0;
            phase_q  <= 1'b0;
            rr_q     <= 1'b0;
            seg_q    <= '1;
        end else begin
            buf_q    <= buf_d;
            count_q  <= count_d;
            offset_q <= offset_d;
            phase_q  <= phase_d;
            rr_q     <= rr_d;
            seg_q    <= seg_d;
        end
    end

    assign o_seg0 = seg_q[0];
    assign o_seg1 = seg_q[1];
    assign o_seg2 = seg_q[2];
    assign o_seg3 = seg_q[3];
    assign o_seg4 = seg_q[4];
    assign o_seg5 = seg_q[5];
    assign o_seg6 = seg_q[6];
    assign o_seg7 = seg_q[7];

endmodule

// File: tb/tb_seg_disp_ctrl.sv
// Scoreboard bench for seg_disp_ctrl with a behavioural model
// of the digit buffer, arbiter, prescaler, scroll and blink.
module tb_seg_disp_ctrl;

    localparam int CN = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [2:0] req0_idx, req1_idx;
    logic [4:0] req0_data, req1_data;
    logic [1:0] mode;
    logic [7:0] dp;
    logic [7:0] o_seg0, o_seg1, o_seg2, o_seg3;
    logic [7:0] o_seg4, o_seg5, o_seg6, o_seg7;

    seg_disp_ctrl #(.CLK_NUM(32'(CN))) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_idx   (req0_idx),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_idx   (req1_idx),
        .req1_data  (req1_data),
        .mode       (mode),
        .dp         (dp),
        .o_seg0     (o_seg0),
        .o_seg1     (o_seg1),
        .o_seg2     (o_seg2),
        .o_seg3     (o_seg3),
        .o_seg4     (o_seg4),
        .o_seg5     (o_seg5),
        .o_seg6     (o_seg6),
        .o_seg7     (o_seg7)
    );

    // staged stimulus, applied at the falling edge
    logic       s_rst, s_v0, s_v1;
    logic [2:0] s_i0, s_i1;
    logic [4:0] s_d0, s_d1;
    logic [1:0] s_mode;
    logic [7:0] s_dp;

    // reference model state
    logic [4:0] m_buf [8];
    int         m_count;
    int         m_off;
    bit         m_phase;
    bit         m_rr;
    int         m_sticks;
    bit         g0, g1;

    logic [7:0] ht [16] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
        8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
    };

    logic [1:0]  rq [$];
    logic [63:0] sq [$];

    int checks   = 0;
    int failures = 0;

    function automatic logic [63:0] all_segs();
        return {o_seg7, o_seg6, o_seg5, o_seg4,
                o_seg3, o_seg2, o_seg1, o_seg0};
    endfunction

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 8; k++) m_buf[k] = 5'h10;
        m_count = 0;
        m_off   = 0;
        m_phase = 0;
        m_rr    = 0;
    endtask

    // One clock: drive, predict the coming edge, push expectations.
    task automatic step();
        logic [63:0] exp;
        logic [4:0]  e;
        logic [7:0]  p;
        bit          tick;
        @(negedge clk);
        rst        = s_rst;
        req0_valid = s_v0;
        req0_idx   = s_i0;
        req0_data  = s_d0;
        req1_valid = s_v1;
        req1_idx   = s_i1;
        req1_data  = s_d1;
        mode       = s_mode;
        dp         = s_dp;
        #1;
        if (s_v0 && s_v1) begin
            g0 = !m_rr;
            g1 = m_rr;
        end else begin
            g0 = s_v0;
            g1 = s_v1;
        end
        rq.push_back({g0, g1});
        if (s_rst) begin
            exp = '1;
            model_reset();
        end else begin
            for (int n = 0; n < 8; n++) begin
                e = m_buf[(m_off + n) % 8];
                p = e[4] ? 8'h00 : ht[e[3:0]];
                if (s_dp[n]) p[0] = 1'b1;
                exp[n*8 +: 8] = m_phase ? 8'hFF : ~p;
            end
            tick = (m_count == CN);
            if (g0) m_buf[s_i0] = s_d0;
            else if (g1) m_buf[s_i1] = s_d1;
            if (g0) m_rr = 1;
            else if (g1) m_rr = 0;
            m_count = tick ? 0 : m_count + 1;
            if (s_mode == 2'b01 && tick) begin
                m_off = (m_off + 1) % 8;
                m_sticks++;
            end
            if (s_mode == 2'b10) m_phase = tick ? !m_phase : m_phase;
            else m_phase = 0;
        end
        sq.push_back(exp);
        if (g0) s_v0 = 0;
        if (g1) s_v1 = 0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wr(input bit r, input logic [2:0] i,
                      input logic [4:0] d);
        bit done = 0;
        if (r) begin
            s_v1 = 1; s_i1 = i; s_d1 = d;
        end else begin
            s_v0 = 1; s_i0 = i; s_d0 = d;
        end
        for (int k = 0; k < 16 && !done; k++) begin
            step();
            done = r ? g1 : g0;
        end
        if (!done) chk("wr_grant_timeout", 0, 1);
    endtask

    task automatic do_reset();
        s_rst = 1;
        step();
        s_rst = 0;
    endtask

    // ready monitor: sampled after inputs settle in the low phase
    initial begin
        logic [1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rq.size() > 0) begin
                e = rq.pop_front();
                chk("ready", {req0_ready, req1_ready}, 64'(e));
            end
        end
    end

    // segment monitor: sampled just after each rising edge
    initial begin
        logic [63:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (sq.size() > 0) begin
                e = sq.pop_front();
                chk("segs", all_segs(), e);
            end
        end
    end

    initial begin
        bit ok;
        rst = 1; req0_valid = 0; req1_valid = 0;
        req0_idx = 0; req0_data = 0;
        req1_idx = 0; req1_data = 0;
        mode = 0; dp = 0;
        s_rst = 1; s_v0 = 0; s_v1 = 0;
        s_i0 = 0; s_d0 = 0; s_i1 = 0; s_d1 = 0;
        s_mode = 0; s_dp = 0;
        m_sticks = 0;
        model_reset();

        // reset and idle
        step();
        step();
        s_rst = 0;
        idle(3);
        chk("idle_segs", all_segs(), '1);
        chk("idle_ready", {req0_ready, req1_ready}, 0);

        // single write from req0
        wr(0, 3'd3, 5'h05);
        idle(2);
        chk("wr_seg3", 64'(o_seg3), 64'h49);
        chk("wr_seg2", 64'(o_seg2), 64'hFF);

        // contention on the same entry
        do_reset();
        idle(1);
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                s_v0 = 1; s_i0 = 0; s_d0 = 5'h01;
            end
            s_v1 = 1; s_i1 = 0; s_d1 = 5'h02;
            step();
            chk($sformatf("alt_grant%0d", i),
                {req0_ready, req1_ready},
                (i % 2 == 0) ? 2'b10 : 2'b01);
        end
        idle(2);
        chk("contend_seg0", 64'(o_seg0), 64'h25);

        // scroll through a full wrap
        do_reset();
        for (int k = 0; k < 8; k++) wr(k[0], 3'(k), 5'(k));
        s_mode = 2'b01;
        m_sticks = 0;
        for (int k = 0; k < 100 && m_sticks < 9; k++) step();
        if (m_sticks < 9) chk("scroll_timeout", 0, 1);
        idle(2);
        chk("scroll_seg0", 64'(o_seg0), 64'h9F);

        // blink with dp on position 0, then leave blink while dark
        s_mode = 2'b10;
        s_dp   = 8'h01;
        idle(20);
        ok = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            step();
            ok = m_phase;
        end
        if (!ok) chk("blink_timeout", 0, 1);
        s_mode = 2'b00;
        idle(3);
        chk("unblink_dp", 64'(o_seg0[0]), 0);
        chk("unblink_lit", 64'(o_seg0 == 8'hFF), 0);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            if (!s_v0 && $urandom_range(0, 2) == 0) begin
                s_v0 = 1;
                s_i0 = 3'($urandom);
                s_d0 = 5'($urandom);
            end
            if (!s_v1 && $urandom_range(0, 2) == 0) begin
                s_v1 = 1;
                s_i1 = 3'($urandom);
                s_d1 = 5'($urandom);
            end
            if ($urandom_range(0, 15) == 0) s_mode = 2'($urandom);
            if ($urandom_range(0, 15) == 0) s_dp = 8'($urandom);
            s_rst = ($urandom_range(0, 63) == 0);
            step();
        end
        s_rst = 0;

        // reset mid-scroll with writes pending
        s_mode = 2'b01;
        s_dp   = 8'h00;
        idle(6);
        s_v0 = 1; s_i0 = 3'd1; s_d0 = 5'h07;
        s_v1 = 1; s_i1 = 3'd2; s_d1 = 5'h08;
        s_rst = 1;
        step();
        s_rst = 0;
        s_v0 = 0;
        s_v1 = 0;
        s_mode = 2'b00;
        step();
        chk("rst_mid_segs", all_segs(), '1);
        idle(3);
        chk("rst_nowrite", all_segs(), '1);

        idle(2);
        @(posedge clk);
        #3;
        chk("drain", 64'(rq.size() + sq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_disp_ctrl.md
Name: seg_disp_ctrl

Overview:
- Display controller for the eight-digit 7-segment bank.
- Two requesters share one 8-entry digit buffer through a round-robin write arbiter.
- A prescaler tick sequences static, scroll and blink presentation modes.
- Drives the eight active-low segment buses directly; replaces hard-wired pattern rotators.

Parameters:
- CLK_NUM, 5000000: prescaler terminal count; tick period is CLK_NUM+1 clk cycles. Legal range 1..2^32-1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 write request
- req0_ready  out  1  requester 0 grant; combinational
- req0_idx  in  3  requester 0 target buffer entry
- req0_data  in  5  requester 0 entry value; bit4=blank, [3:0]=hex digit
- req1_valid  in  1  requester 1 write request
- req1_ready  out  1  requester 1 grant; combinational
- req1_idx  in  3  requester 1 target buffer entry
- req1_data  in  5  requester 1 entry value; same encoding as req0_data
- mode  in  2  00 static, 01 scroll, 10 blink, 11 treated as static
- dp  in  8  decimal-point enable per physical position; dp[N] applies to o_segN
- o_seg0..o_seg7  out  8 each  active-low segment buses, registered

Behaviour:
- Reset (rst=1 at a posedge):
  - buffer entries all 5'h10 (blank); all o_segN = 8'hFF
  - count=0, offset=0, phase=0, rr pointer=0 (req0 favoured)
- Arbiter:
  - at most one write per cycle; readyX is combinational from the valids and the rr pointer
  - only one valid: that requester is granted
  - both valid: the pointer's requester is granted
  - after any grant, the pointer moves to the other requester
  - no grant when neither is valid; pointer holds
  - a granted write (valid & ready) updates buffer[idx] at that posedge
  - requesters hold valid/idx/data until ready; an ungranted request is never dropped
  - both requesters targeting the same idx are served on consecutive cycles; the later write wins
- Prescaler:
  - count increments each cycle; wraps to 0 when count==CLK_NUM
  - tick = (count==CLK_NUM), one cycle wide
- Scroll:
  - in mode 01, offset <= offset+1 (3-bit, wraps 7->0) on tick
  - in other modes offset holds its value and is not cleared
- Blink:
  - in mode 10, phase toggles on tick
  - in any other mode phase is forced to 0 on the next cycle
- Output mapping:
  - physical position N shows entry E = (offset+N) mod 8
  - pattern = hex decode of buffer[E][3:0], or 8'h00 if buffer[E][4]=1; then bit0 |= dp[N]
  - o_segN <= ~pattern, except o_segN <= 8'hFF when phase=1
- Pattern bit order: bit7=a .. bit1=g, bit0=dp.
- Hex table: 0:FC 1:60 2:DA 3:F2 4:66 5:B6 6:BE 7:E0 8:FE 9:F6 A:EE b:3E C:9C d:7A E:9E F:8E.
- Latency:
  - a write at edge T appears on o_seg at edge T+1
  - an offset or phase change at edge T appears at edge T+1
  - a write and a tick at the same edge both take effect; the next output reflects both
- Reset mid-operation: all state returns to reset values at that edge; readyX may be high during rst but writes are ignored.

Decomposition:
- Package seg_pkg holds:
  - mode encodings MODE_STATIC/MODE_SCROLL/MODE_BLINK
  - BLANK = 5'h10
  - the 16-entry hex-to-segment constant table
- Sub-module seg_hex_dec: combinational 5-bit entry to 8-bit active-high pattern, instantiated 8 times.

Test Plan:
- Reset, then idle with mode=00, dp=0 -> all o_segN=8'hFF; req0_ready=req1_ready=0.
- req0 writes idx3=5'h05, mode=00 -> two cycles after the write edge, o_seg3=~8'hB6=8'h49; the others stay 8'hFF.
- Both valid for 4 cycles, req0 idx0=1, req1 idx0=2, starting after reset -> grants alternate 0,1,0,1; final buffer[0]=2 and o_seg0=~8'hDA=8'h25.
- CLK_NUM=3, buffer[k]=k, mode=01 -> offset advances every 4 cycles; after 9 ticks (wrap past 7->0) o_seg0 shows digit 1 (8'h9F).
- CLK_NUM=3, mode=10, dp=8'h01 -> outputs alternate every 4 cycles between 8'hFF and decoded values; o_seg0 bit0=0 when lit. Switching to mode=00 mid-blank restores output within 2 cycles.
- rst asserted mid-scroll with writes pending -> next cycle offset=0 and outputs 8'hFF; no write from the rst cycle lands.
